sprite_index_fetch: RTL and testbench
=====================================

// Module: sprite_index_fetch
// PURPOSE
//  Upstream feeder of the per-sprite palette lookup. Maps the VGA scan position
//  (DrawX/DrawY) onto an animated, optionally mirrored sprite stored in a
//  4-bit-index ROM (1-cycle read latency). Emits the palette index plus an opaque flag.
//  The flag is pipeline-aligned so the palette's RGB can be muxed over the background.
//  Also steps the animation frame on vertical-sync boundaries.
// PARAMETERS
//  SPR_W       64  sprite width in pixels (power of 2)
//  SPR_H       64  sprite height in pixels
//  NUM_FRAMES  4   animation frames stored back-to-back in ROM
//  FRAME_DIV   6   frame_start pulses per animation step (>=1)
//  TRANSP_IDX  3   palette index treated as transparent (entry 3 = black)
//  ADDR_W      14  ROM address width; must hold NUM_FRAMES*SPR_W*SPR_H-1
// PORTS
//  Clk          in   1       system clock, one clock domain
//  Reset_n      in   1       asynchronous, active-low reset
//  frame_start  in   1       1-cycle pulse at start of vertical blank
//  anim_en      in   1       1: animation advances; 0: frame held
//  anim_restart in   1       1-cycle pulse: jump to frame 0, clear divider
//  sprite_x     in   10      sprite top-left X (screen px)
//  sprite_y     in   10      sprite top-left Y (screen px)
//  flip_h       in   1       1: mirror sprite horizontally
//  DrawX        in   10      current scan X
//  DrawY        in   10      current scan Y
//  rom_addr     out  ADDR_W  registered ROM read address
//  rom_data     in   4       ROM index, valid the cycle after rom_addr
//  index        out  4       palette index to the palette stage
//  pixel_on     out  1       1: inside sprite and rom_data != TRANSP_IDX
//  frame_idx    out  $clog2(NUM_FRAMES)  current animation frame
// BEHAVIOUR
//  Reset (async assert, sync release): rom_addr=0, index=0, pixel_on=0, frame_idx=0.
//  Reset also clears the divider, all pipeline valid bits and the shadow regs (0).
//  Shadow regs: sprite_x/y/flip_h are latched on frame_start only. All position
//   math uses the shadows. Mid-frame input changes never tear the image.
//  Stage 1 (cycle T->T+1): in_box = DrawX>=sx && DrawX<sx+SPR_W &&
//   DrawY>=sy && DrawY<sy+SPR_H. Sums are 11-bit: no wrap, partial off-screen ok.
//   lx = DrawX-sx; mirrored lx = SPR_W-1-lx when flip_h. ly = DrawY-sy.
//   rom_addr <= frame_idx*SPR_W*SPR_H + ly*SPR_W + lx when in_box.
//   Out of box, rom_addr holds its previous value.
//   in_box is piped as v1.
//  Stage 2 (T+2): rom_data valid; v2<=v1; data captured.
//  Stage 3 (T+3): index<=rom_data; pixel_on<=v2 && rom_data!=TRANSP_IDX.
//  Latency is exactly 3 Clk from DrawX/DrawY to index/pixel_on.
//  Outside the box: index=0, pixel_on=0.
//  Animation: div counts accepted frame_start pulses 0..FRAME_DIV-1.
//   At wrap it clears and frame_idx increments; NUM_FRAMES-1 -> 0.
//   A frame_idx change takes effect on the first stage-1 address after the pulse.
//   anim_en=0: div and frame_idx hold; shadows still latch on frame_start.
//   anim_restart has priority over frame_start the same cycle:
//    frame_idx=0, div=0, and shadows still latch.
//   FRAME_DIV=1: frame advances on every frame_start.
//  Reset mid-line: pipeline flushes; pixel_on=0 until 3 cycles after release.
// STRUCTURE
//  sprite_pkg: SPR_W/SPR_H/NUM_FRAMES defaults, TRANSP_IDX, FRAME_BASE(f) function.
//  Sub-module anim_frame_counter: frame_start, anim_en, anim_restart -> frame_idx.
//  Top holds shadow regs, box/addr math and 3-stage alignment pipe.
// TESTING
//  1 Defaults, shadow pos (100,50), flip=0, frame 0; DrawX/Y=(100,50)
//    -> rom_addr=0 at T+1; index=rom[0] at T+3.
//  2 Same position, flip=1, DrawX=100 -> rom_addr=63; DrawX=163 -> 0;
//    DrawX=164 -> pixel_on=0.
//  3 ROM returns 3 inside box -> pixel_on=0; returns 5 -> pixel_on=1, index=5.
//  4 anim_en=1, 6 frame_start pulses -> frame_idx 0->1; (1,0) -> rom_addr=4096.
//    24 pulses total -> frame_idx back to 0.
//  5 anim_restart and frame_start same cycle at frame 2 -> frame_idx=0, div=0.
//    Change sprite_x mid-frame -> box unchanged until next frame_start.
//  6 Sprite at (600,450), DrawX=639 -> in box, no wrap. Reset_n low mid-line
//    -> outputs 0 immediately; pixel_on stays 0 for 3 Clk after release.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite geometry defaults, transparent index and frame base helper.
package sprite_pkg;

  localparam int unsigned SPR_W_D      = 64;
  localparam int unsigned SPR_H_D      = 64;
  localparam int unsigned NUM_FRAMES_D = 4;
  localparam int unsigned FRAME_DIV_D  = 6;
  localparam int unsigned ADDR_W_D     = 14;
  localparam logic [3:0]  TRANSP_IDX   = 4'd3;

  // ROM offset of animation frame f; frames are stored back to back.
  function automatic logic [31:0] FRAME_BASE(input logic [31:0] f,
                                             input logic [31:0] fsz = SPR_W_D * SPR_H_D);
    return f * fsz;
  endfunction

endpackage

// File: rtl/anim_frame_counter.sv
// Animation stepper: divides frame_start pulses and cycles the frame index.
module anim_frame_counter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_FRAMES = NUM_FRAMES_D,
  parameter int unsigned FRAME_DIV  = FRAME_DIV_D
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_start,
  input  logic                          anim_en,
  input  logic                          anim_restart,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx
);

  localparam int unsigned FW = $clog2(NUM_FRAMES);
  localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [DW-1:0] div;

  // Restart wins over a coincident frame_start; otherwise step on divider wrap.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div       <= '0;
      frame_idx <= '0;
    end else if (anim_restart) begin
      div       <= '0;
      frame_idx <= '0;
    end else if (frame_start && anim_en) begin
      if (div == DW'(FRAME_DIV - 1)) begin
        div       <= '0;
        frame_idx <= (frame_idx == FW'(NUM_FRAMES - 1)) ? '0 : frame_idx + FW'(1);
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_index_fetch.sv
// Scan position -> sprite ROM address, then ROM index + opaque flag 3 clocks later.
module sprite_index_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = SPR_W_D,
  parameter int unsigned SPR_H      = SPR_H_D,
  parameter int unsigned NUM_FRAMES = NUM_FRAMES_D,
  parameter int unsigned FRAME_DIV  = FRAME_DIV_D,
  parameter logic [3:0]  TRANSP     = TRANSP_IDX,
  parameter int unsigned ADDR_W     = ADDR_W_D
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_start,
  input  logic                          anim_en,
  input  logic                          anim_restart,
  input  logic [9:0]                    sprite_x,
  input  logic [9:0]                    sprite_y,
  input  logic                          flip_h,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [3:0]                    rom_data,
  output logic [3:0]                    index,
  output logic                          pixel_on,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx
);

  localparam int unsigned LXW    = $clog2(SPR_W);
  localparam int unsigned LYW    = $clog2(SPR_H);
  localparam int unsigned FSZ    = SPR_W * SPR_H;
  localparam int unsigned STAGES = 1;

  logic [9:0]        sx, sy;
  logic              sflip;
  logic              in_box;
  logic [LXW-1:0]    lx, lx_m;
  logic [LYW-1:0]    ly;
  logic [ADDR_W-1:0] addr_next;
  logic [STAGES:0]   vld_pipe;

  anim_frame_counter #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_DIV  (FRAME_DIV)
  ) u_anim (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_start  (frame_start),
    .anim_en      (anim_en),
    .anim_restart (anim_restart),
    .frame_idx    (frame_idx)
  );

  // Position shadows only move at vblank so a frame never tears.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx    <= '0;
      sy    <= '0;
      sflip <= 1'b0;
    end else if (frame_start) begin
      sx    <= sprite_x;
      sy    <= sprite_y;
      sflip <= flip_h;
    end
  end

  // Box test in 11 bits so a sprite hanging off the right/bottom edge cannot wrap.
  always_comb begin
    in_box = ({1'b0, DrawX} >= {1'b0, sx}) && ({1'b0, DrawX} < {1'b0, sx} + 11'(SPR_W)) &&
             ({1'b0, DrawY} >= {1'b0, sy}) && ({1'b0, DrawY} < {1'b0, sy} + 11'(SPR_H));
    lx        = LXW'(DrawX - sx);
    ly        = LYW'(DrawY - sy);
    lx_m      = sflip ? LXW'(SPR_W - 1) - lx : lx;
    addr_next = ADDR_W'(FRAME_BASE(32'(frame_idx), 32'(FSZ)) + 32'(ly) * 32'(SPR_W) + 32'(lx_m));
  end

  // Stage 1: register the ROM address; hold it outside the box to avoid needless toggling.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    rom_addr <= '0;
    else if (in_box) rom_addr <= addr_next;
  end

  // Valid bits ride alongside the ROM read latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) vld_pipe <= '0;
    else          vld_pipe <= {vld_pipe[STAGES-1:0], in_box};
  end

  // Stage 3: index is zeroed outside the box; transparent entries are not "on".
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      index    <= '0;
      pixel_on <= 1'b0;
    end else begin
      index    <= vld_pipe[STAGES] ? rom_data : 4'd0;
      pixel_on <= vld_pipe[STAGES] && (rom_data != TRANSP);
    end
  end

endmodule

// File: tb/tb_sprite_index_fetch.sv
// Bench for sprite_index_fetch: vector table, animation/reset sequences, random stream.
module tb_sprite_index_fetch;

  localparam int SW = 64, SH = 64, NF = 4, FD = 6;

  logic        Clk, Reset_n;
  logic        frame_start, anim_en, anim_restart, flip_h;
  logic [9:0]  sprite_x, sprite_y, DrawX, DrawY;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data, index;
  logic        pixel_on;
  logic [1:0]  frame_idx;

  sprite_index_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .anim_en(anim_en),
    .anim_restart(anim_restart), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .flip_h(flip_h), .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr),
    .rom_data(rom_data), .index(index), .pixel_on(pixel_on), .frame_idx(frame_idx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous ROM with one cycle of read latency.
  logic [3:0] rom [0:16383];
  always @(posedge Clk) rom_data <= rom[rom_addr];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: shadow position, count of accepted pulses, last in-box address.
  int m_sx, m_sy, m_flip, m_cnt, m_last;
  typedef struct { int addr; int idx; int pon; } exp_t;
  exp_t h [4];

  function automatic int m_frame();
    return (m_cnt / FD) % NF;
  endfunction

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_flip = 0; m_cnt = 0; m_last = 0;
    for (int i = 0; i < 4; i++) h[i] = '{0, 0, 0};
  endtask

  // Drive one scan cycle, advance the model, clock, then compare aged expectations.
  task automatic pix(input int dx, input int dy, input logic fs, input logic rs);
    int lx, addr;
    bit inb;
    exp_t e;
    DrawX = 10'(dx); DrawY = 10'(dy); frame_start = fs; anim_restart = rs;
    inb = (dx >= m_sx) && (dx < m_sx + SW) && (dy >= m_sy) && (dy < m_sy + SH);
    lx = m_flip ? (SW - 1 - (dx - m_sx)) : (dx - m_sx);
    addr = m_frame() * SW * SH + (dy - m_sy) * SW + lx;
    if (inb) m_last = addr;
    e.addr = m_last;
    e.idx  = inb ? int'(rom[addr]) : 0;
    e.pon  = (inb && rom[addr] != 4'd3) ? 1 : 0;
    h[3] = h[2]; h[2] = h[1]; h[1] = e;
    if (rs) m_cnt = 0;
    else if (fs && anim_en) m_cnt++;
    if (fs) begin m_sx = sprite_x; m_sy = sprite_y; m_flip = flip_h; end
    @(posedge Clk); #1;
    frame_start = 1'b0; anim_restart = 1'b0;
    chk("rom_addr", rom_addr, h[1].addr);
    chk("index", index, h[3].idx);
    chk("pixel_on", pixel_on, h[3].pon);
    chk("frame_idx", frame_idx, m_frame());
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pix(0, 0, 1'b1, 1'b0);
      pix(0, 0, 1'b0, 1'b0);
    end
  endtask

  typedef struct {
    logic fs; int sx; int sy; logic fl; int dx; int dy; logic c; int addr;
  } vec_t;
  vec_t vt [17];

  initial begin
    Reset_n = 1'b0; frame_start = 0; anim_en = 0; anim_restart = 0; flip_h = 0;
    sprite_x = 0; sprite_y = 0; DrawX = 0; DrawY = 0;
    for (int i = 0; i < 16384; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[0] = 4'd5; rom[1] = 4'd3;

    vt[0]  = '{1, 100, 50, 0,   0,   0, 0,    0};
    vt[1]  = '{0, 100, 50, 0, 100,  50, 1,    0};
    vt[2]  = '{0, 100, 50, 0, 101,  50, 1,    1};
    vt[3]  = '{0, 100, 50, 0, 163,  51, 1,  127};
    vt[4]  = '{0, 100, 50, 0,  99,  50, 1,  127};
    vt[5]  = '{0, 100, 50, 0, 100, 113, 1, 4032};
    vt[6]  = '{0, 100, 50, 0, 100, 114, 1, 4032};
    vt[7]  = '{1, 100, 50, 1,   0,   0, 0,    0};
    vt[8]  = '{0, 100, 50, 1, 100,  50, 1,   63};
    vt[9]  = '{0, 100, 50, 1, 163,  50, 1,    0};
    vt[10] = '{0, 100, 50, 1, 164,  50, 1,    0};
    vt[11] = '{0, 100, 50, 1, 110,  52, 1,  181};
    vt[12] = '{0, 300, 50, 1, 100,  50, 1,   63};
    vt[13] = '{1, 600, 450, 0, 639, 479, 1,  63};
    vt[14] = '{0, 600, 450, 0, 639, 479, 1, 1895};
    vt[15] = '{0, 600, 450, 0, 599, 450, 1, 1895};
    vt[16] = '{0, 600, 450, 0, 600, 450, 1,    0};

    #12;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_index", index, 0);
    chk("rst_pixel_on", pixel_on, 0);
    chk("rst_frame_idx", frame_idx, 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    model_reset();

    // Vector table: geometry, mirroring, edges, shadowing.
    for (int i = 0; i < 17; i++) begin
      sprite_x = 10'(vt[i].sx); sprite_y = 10'(vt[i].sy); flip_h = vt[i].fl;
      pix(vt[i].dx, vt[i].dy, vt[i].fs, 1'b0);
      if (vt[i].c) chk("tbl_addr", rom_addr, vt[i].addr);
    end
    for (int i = 0; i < 3; i++) pix(0, 0, 1'b0, 1'b0);

    // Animation divider and wrap.
    anim_en = 1'b1;
    pulses(6);
    chk("anim_step", frame_idx, 1);
    pix(600, 450, 1'b0, 1'b0);
    chk("frame1_addr", rom_addr, 4096);
    pulses(18);
    chk("anim_wrap", frame_idx, 0);
    pulses(12);
    chk("anim_f2", frame_idx, 2);
    pix(0, 0, 1'b1, 1'b1);
    chk("restart", frame_idx, 0);
    pulses(5);
    chk("restart_div0", frame_idx, 0);
    pulses(1);
    chk("restart_step", frame_idx, 1);
    anim_en = 1'b0;
    pulses(6);
    chk("anim_hold", frame_idx, 1);

    // Randomised stream against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        sprite_x = 10'($urandom_range(0, 639)); sprite_y = 10'($urandom_range(0, 479));
        flip_h = 1'($urandom_range(0, 1));
      end
      anim_en = ($urandom_range(0, 3) != 0);
      pix((m_sx + int'($urandom_range(0, 79)) - 8) & 1023,
          (m_sy + int'($urandom_range(0, 79)) - 8) & 1023,
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    end

    // Mid-line reset while streaming through the sprite.
    rom[0] = 4'd5;
    sprite_x = 10'd0; sprite_y = 10'd0; flip_h = 1'b0;
    pix(0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pix(0, 0, 1'b0, 1'b0);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_index", index, 0);
    chk("mid_rst_pixel_on", pixel_on, 0);
    chk("mid_rst_rom_addr", rom_addr, 0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) pix(0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        sprite_x = 10'($urandom_range(560, 639)); sprite_y = 10'($urandom_range(400, 479));
        flip_h = 1'($urandom_range(0, 1));
      end
      anim_en = 1'b1;
      pix((m_sx + int'($urandom_range(0, 79)) - 8) & 1023,
          (m_sy + int'($urandom_range(0, 79)) - 8) & 1023,
          1'($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
